// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state encoding and counter sizing helper for shift_ctrl.
// Items: state_t with S_IDLE/S_SHIFT/S_DONE, cnt_w() = clog2 with a 1-bit floor.
package shift_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if: word-in / serial-out bundle for shift_ctrl.
// Ports: in_data/in_valid/abort (master->slave), in_ready/sout/sout_en/busy/done (slave->master).
interface shift_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             sout;
    logic             sout_en;
    logic             busy;
    logic             done;

    modport master (
        output in_data, in_valid, abort,
        input  in_ready, sout, sout_en, busy, done
    );

    modport slave (
        input  in_data, in_valid, abort,
        output in_ready, sout, sout_en, busy, done
    );
endinterface

// File: rtl/shift_ctrl_sreg.sv
// shift_ctrl_sreg: right-shifting word register, LSB is the serial bit.
// Ports: CLK, clr (sync clear, highest priority), load + d, shift, lsb.
module shift_ctrl_sreg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             lsb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge CLK) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign lsb = q[0];

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: serializes a WIDTH-bit word LSB first, each bit held DIV cycles.
// Ports: CLK, RST (sync, active high), bus (shift_ctrl_if.slave). Macro SHIFT_CTRL_PARITY_EN adds an even-parity bit.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    shift_ctrl_if.slave  bus
);

`ifdef SHIFT_CTRL_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int BW = cnt_w(WIDTH + 2);
    localparam int DW = cnt_w(DIV + 1);

    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          sreg_lsb;
    logic          sout_bit;

    logic accept;
    logic in_shift;
    logic bit_end;
    logic frame_end;
    logic kill;

    // RST and ABORT both discard the frame; ABORT in IDLE only blocks accept.
    assign kill      = RST || (bus.abort && state != S_IDLE);
    assign accept    = state == S_IDLE && bus.in_valid && !bus.abort;
    assign in_shift  = state == S_SHIFT;
    assign bit_end   = in_shift && div_cnt == DIV_LAST;
    assign frame_end = bit_end && bit_cnt == BIT_LAST;

    shift_ctrl_sreg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .CLK   (CLK),
        .clr   (kill),
        .load  (accept),
        .shift (bit_end),
        .d     (bus.in_data),
        .lsb   (sreg_lsb)
    );

    // bit_cnt tops out at NBITS after the last bit and holds until the next accept.
    always_ff @(posedge CLK) begin
        if (kill) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        state   <= S_SHIFT;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (bit_end) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (frame_end) begin
                            state <= S_DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_CTRL_PARITY_EN
    logic par_q;

    always_ff @(posedge CLK) begin
        if (kill) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^bus.in_data;
        end
    end

    assign sout_bit = (bit_cnt == BW'(WIDTH)) ? par_q : sreg_lsb;
`else
    assign sout_bit = sreg_lsb;
`endif

    // Outputs are forced low combinationally while RST is held.
    assign bus.sout     = !RST && in_shift && sout_bit;
    assign bus.sout_en  = !RST && in_shift;
    assign bus.busy     = !RST && state != S_IDLE;
    assign bus.done     = !RST && state == S_DONE;
    assign bus.in_ready = !RST && state == S_IDLE;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed scoreboard bench for shift_ctrl in three configurations.
// Instances: ua W4/D1, ub W4/D3, uc W8/D1; sel picks which one is driven and observed.
module tb_shift_ctrl;

`ifdef SHIFT_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk;
    logic        rst;
    logic        vld;
    logic        abort;
    logic [31:0] din;
    logic [1:0]  sel;

    int nchk;
    int nfail;
    int cyc;
    int acc;
    int prev_acc;

    logic sbq[$];

    logic obs_sout;
    logic obs_en;
    logic obs_busy;
    logic obs_done;
    logic obs_ready;

    shift_ctrl_if #(.WIDTH(4)) a_if ();
    shift_ctrl_if #(.WIDTH(4)) b_if ();
    shift_ctrl_if #(.WIDTH(8)) c_if ();

    assign a_if.in_data  = din[3:0];
    assign a_if.in_valid = vld && sel == 2'd0;
    assign a_if.abort    = abort && sel == 2'd0;
    assign b_if.in_data  = din[3:0];
    assign b_if.in_valid = vld && sel == 2'd1;
    assign b_if.abort    = abort && sel == 2'd1;
    assign c_if.in_data  = din[7:0];
    assign c_if.in_valid = vld && sel == 2'd2;
    assign c_if.abort    = abort && sel == 2'd2;

    shift_ctrl #(.WIDTH(4), .DIV(1)) ua (.CLK(clk), .RST(rst), .bus(a_if));
    shift_ctrl #(.WIDTH(4), .DIV(3)) ub (.CLK(clk), .RST(rst), .bus(b_if));
    shift_ctrl #(.WIDTH(8), .DIV(1)) uc (.CLK(clk), .RST(rst), .bus(c_if));

    always_comb begin
        obs_sout  = a_if.sout;
        obs_en    = a_if.sout_en;
        obs_busy  = a_if.busy;
        obs_done  = a_if.done;
        obs_ready = a_if.in_ready;
        if (sel == 2'd1) begin
            obs_sout  = b_if.sout;
            obs_en    = b_if.sout_en;
            obs_busy  = b_if.busy;
            obs_done  = b_if.done;
            obs_ready = b_if.in_ready;
        end else if (sel == 2'd2) begin
            obs_sout  = c_if.sout;
            obs_en    = c_if.sout_en;
            obs_busy  = c_if.busy;
            obs_done  = c_if.done;
            obs_ready = c_if.in_ready;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_en"}, {31'd0, obs_en}, 0);
        chk({tag, "_done"}, {31'd0, obs_done}, 0);
        chk({tag, "_busy"}, {31'd0, obs_busy}, 0);
        chk({tag, "_sout"}, {31'd0, obs_sout}, 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the next IDLE cycle.
    task automatic send(input logic [31:0] d, input bit hold);
        int   w;
        int   dv;
        int   nb;
        logic p;
        logic e;
        w  = (sel == 2'd2) ? 8 : 4;
        dv = (sel == 2'd1) ? 3 : 1;
        nb = w + PAR;
        chk("ready_idle", {31'd0, obs_ready}, 1);
        din = d;
        vld = 1'b1;
        p   = 1'b0;
        for (int i = 0; i < w; i++) begin
            p = p ^ d[i];
            for (int k = 0; k < dv; k++) sbq.push_back(d[i]);
        end
        if (PAR != 0) begin
            for (int k = 0; k < dv; k++) sbq.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        if (hold && prev_acc >= 0) chk("spacing", acc - prev_acc, nb * dv + 2);
        prev_acc = acc;
        if (!hold) vld = 1'b0;
        din = ~d;
        for (int j = 0; j < nb * dv; j++) begin
            if (j > 0) @(negedge clk);
            chk("sout_en", {31'd0, obs_en}, 1);
            chk("busy_shift", {31'd0, obs_busy}, 1);
            chk("ready_shift", {31'd0, obs_ready}, 0);
            e = (sbq.size() > 0) ? sbq.pop_front() : 1'bx;
            chk("sout", {31'd0, obs_sout}, {31'd0, e});
        end
        @(negedge clk);
        chk("done_pulse", {31'd0, obs_done}, 1);
        chk("done_en", {31'd0, obs_en}, 0);
        chk("done_busy", {31'd0, obs_busy}, 1);
        chk("done_ready", {31'd0, obs_ready}, 0);
        chk("done_sout", {31'd0, obs_sout}, 0);
        @(negedge clk);
        chk("post_ready", {31'd0, obs_ready}, 1);
        idle_chk("post");
        chk("sbq_drained", sbq.size(), 0);
    endtask

    initial begin
        nchk     = 0;
        nfail    = 0;
        prev_acc = -1;
        rst      = 1'b1;
        vld      = 1'b0;
        abort    = 1'b0;
        din      = '0;
        sel      = 2'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, obs_ready}, 0);
        idle_chk("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, obs_ready}, 1);
        idle_chk("rel");

        send(32'hB, 1'b0);
        send(32'h0, 1'b0);
        send(32'hF, 1'b0);

        sel = 2'd1;
        send(32'h6, 1'b0);

        sel = 2'd2;
        din = 32'h3E;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        chk("ab_c1_sout", {31'd0, obs_sout}, 0);
        @(negedge clk);
        chk("ab_c2_sout", {31'd0, obs_sout}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_ready", {31'd0, obs_ready}, 1);
        idle_chk("ab");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_chk("ab_quiet");
        end
        send(32'hA5, 1'b0);

        sel = 2'd0;
        din = 32'hD;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        chk("rf_c1_en", {31'd0, obs_en}, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rf_in_ready", {31'd0, obs_ready}, 0);
        idle_chk("rf_in");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rf_ready", {31'd0, obs_ready}, 1);
        idle_chk("rf");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle_chk("rf_quiet");
        end

        vld   = 1'b1;
        abort = 1'b1;
        din   = 32'h9;
        @(negedge clk);
        vld   = 1'b0;
        abort = 1'b0;
        chk("va_ready", {31'd0, obs_ready}, 1);
        idle_chk("va");
        @(negedge clk);
        idle_chk("va2");

`ifdef SHIFT_CTRL_PARITY_EN
        send(32'h7, 1'b0);
        send(32'h3, 1'b0);
`endif

        sel      = 2'd1;
        prev_acc = -1;
        for (int n = 0; n < 20; n++) begin
            send({28'd0, 4'($urandom_range(0, 15))}, 1'b1);
        end
        vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        idle_chk("b2b_end");

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data word length in bits (legal 2..32).
REQ-002 Parameter DIV, default 1, clock cycles each serial bit is held (legal 1..256).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: port CLK, input, 1 bit, rising-edge clock; port RST, input, 1 bit, synchronous active-high reset.
REQ-004 IN_DATA input WIDTH: parallel word to serialize.
REQ-005 IN_VALID input 1: IN_DATA is valid.
REQ-006 IN_READY output 1: block can accept a word.
REQ-007 ABORT input 1: cancel the frame in progress.
REQ-008 SOUT output 1: serial data bit.
REQ-009 SOUT_EN output 1: SOUT is carrying a valid frame bit.
REQ-010 BUSY output 1: frame in progress.
REQ-011 DONE output 1: one-cycle pulse marking frame completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, IN_READY=1. The FSM stays in IDLE unless IN_VALID=1 at a rising edge.
REQ-014 On that edge (the accept edge), the block SHALL perform four actions:
- capture IN_DATA into an internal shift register;
- clear the bit counter;
- clear the divider counter;
- move to SHIFT.
REQ-015 IN_READY SHALL be 0 in SHIFT and in DONE. IN_DATA changes outside IDLE SHALL be ignored.
REQ-016 In SHIFT, SOUT_EN=1 and BUSY=1. SOUT SHALL equal the LSB of the shift register, so bits go out LSB first.
REQ-017 Each bit SHALL be held for exactly DIV cycles. The divider counter counts 0..DIV-1. At wrap it resets to 0, the shift register shifts right by one, and the bit counter increments.
REQ-018 After the last bit's DIV cycles, the FSM SHALL move to DONE. A frame therefore occupies exactly NBITS*DIV cycles of SHIFT, where NBITS=WIDTH, or WIDTH+1 with parity enabled.
REQ-019 DONE SHALL last exactly one cycle, with DONE=1, BUSY=1 and SOUT_EN=0, and then return to IDLE.
REQ-020 Minimum spacing between accept edges is NBITS*DIV+2 cycles.
REQ-021 Outside SHIFT, SOUT SHALL be 0.
REQ-022 If ABORT=1 at an edge in SHIFT or DONE, the FSM SHALL go to IDLE with no DONE pulse. Counters and the shift register SHALL clear.
REQ-023 ABORT=1 in IDLE SHALL block acceptance on that edge, even when IN_VALID=1; ABORT takes priority.
REQ-024 The bit counter SHALL be sized as clog2(WIDTH+2) and the divider counter as clog2(DIV+1). Neither counter SHALL wrap past its terminal value.

Reset
REQ-025 When RST=1 at a rising edge, the block SHALL enter IDLE, and every counter and the shift register SHALL clear.
REQ-026 Output values in reset:
- IN_READY=1 from the first edge after RST deasserts;
- during reset, SOUT=0, SOUT_EN=0, BUSY=0, DONE=0 and IN_READY=0.
REQ-027 RST asserted mid-frame SHALL discard the frame with no DONE pulse. RST takes priority over ABORT and IN_VALID.

Configuration
REQ-028 The macro SHIFT_CTRL_PARITY_EN SHALL control the parity bit.
- Defined: after the WIDTH data bits, one even-parity bit (XOR of the captured word) is sent for DIV cycles with SOUT_EN=1, so NBITS=WIDTH+1.
- Undefined: no parity bit, NBITS=WIDTH, and no parity logic is synthesized.

Structure
REQ-029 The package shift_ctrl_pkg SHALL contain:
- the state typedef (IDLE/SHIFT/DONE);
- the width-computation function for the counter sizes.
REQ-030 The shift register SHALL be a sub-module, shift_ctrl_sreg (parallel load, shift-enable, synchronous clear). The FSM and the counters SHALL stay in shift_ctrl.

Verification
REQ-031 WIDTH=4, DIV=1, data 4'b1011 accepted at edge 0: SOUT=1,1,0,1 in cycles 1-4 with SOUT_EN=1, DONE=1 in cycle 5, IN_READY=1 in cycle 6.
REQ-032 WIDTH=4, DIV=3, data 4'b0110: each bit is held 3 cycles (0,0,0,1,1,1,1,1,1,0,0,0), and DONE follows in cycle 13.
REQ-033 ABORT pulsed in cycle 2 of a WIDTH=8, DIV=1 frame: IDLE next cycle, no DONE, SOUT_EN=0, IN_READY=1. A new word 8'hA5 is then accepted and sent correctly.
REQ-034 RST asserted mid-frame, and IN_VALID=1 together with ABORT=1 in IDLE: both give no acceptance, all outputs at reset values, BUSY=0.
REQ-035 With SHIFT_CTRL_PARITY_EN defined, WIDTH=4, DIV=1: data 4'b0111 gives SOUT=1,1,1,0 then parity bit 1, and DONE in cycle 6. Data 4'b0011 gives parity bit 0.
REQ-036 Back-to-back traffic with IN_VALID held high and 20 random words: each word is accepted exactly on the first IDLE cycle, and spacing equals NBITS*DIV+2 cycles.
